v_red_unit: RTL and testbench

Multi-cycle vector reduction unit executing VRED_VREDSUM and VRED_VREDMAX (vred_op encodings) at SEW 8/16/32 (vsew encodings).
Sits downstream of the vector decoder/issue stage, which supplies the vs2 register contents, the vs1 scalar element and the decoded op.
Produces one scalar result per request, destined for element 0 of vd via the register-file writeback.
Processes one element per cycle under a valid/ready handshake on both sides.

---
 rtl/v_red_unit.sv | 91 +++++++++
 tb/tb_v_red_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/v_red_unit.sv
// v_red_unit: multi-cycle SUM/MAX reduction of a vector register into a sign-extended scalar.
module v_red_unit #(
    parameter int VLEN = 128,
    parameter int VLW  = $clog2(VLEN/8)+1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [1:0]      in_vsew,
    input  logic [VLW-1:0]  in_vl,
    input  logic [VLEN-1:0] in_vs2,
    input  logic [31:0]     in_vs1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic            out_err
);
    localparam int IW = $clog2(VLEN/8);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_n;
    logic [2:0]      op;
    logic [1:0]      vsew;
    logic [VLEN-1:0] vs2;
    logic [VLW-1:0]  vl_eff, vlmax_in, vl_in;
    logic [IW-1:0]   idx;
    logic [31:0]     acc, e, sum;
    logic [IW+4:0]   shamt;
    logic            err, valid_q, legal, accept, last;

    function automatic logic [31:0] sext(input logic [31:0] v, input logic [1:0] sew);
        return sew == 2'd0 ? {{24{v[7]}}, v[7:0]} : sew == 2'd1 ? {{16{v[15]}}, v[15:0]} : v;
    endfunction

    assign legal    = (in_op == 3'd1 || in_op == 3'd2) && in_vsew != 2'd3;
    assign vlmax_in = VLW'(VLEN/8) >> in_vsew;
    assign vl_in    = in_vl > vlmax_in ? vlmax_in : in_vl;
    assign accept   = in_valid && state == IDLE && !flush;
    assign shamt    = (IW+5)'({idx, 3'b000}) << vsew;
    assign e        = sext(32'(vs2 >> shamt), vsew);
    assign sum      = sext(acc + e, vsew);
    assign last     = VLW'(idx) == vl_eff - VLW'(1);

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        if (flush)                state_n = IDLE;
        else if (state == IDLE)   state_n = in_valid ? (legal && vl_in != '0 ? ACCUM : DONE) : IDLE;
        else if (state == ACCUM)  state_n = last ? DONE : ACCUM;
        else if (state == DONE)   state_n = valid_q && out_ready ? IDLE : DONE;
    end

    always_comb begin
        in_ready   = state == IDLE;
        out_valid  = valid_q;
        out_result = valid_q ? acc : '0;
        out_err    = valid_q & err;
    end

    // Result becomes visible on the second DONE cycle, giving the vl_eff+1 latency.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            op      <= '0;
            vsew    <= '0;
            vs2     <= '0;
            vl_eff  <= '0;
            idx     <= '0;
            acc     <= '0;
            err     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= state == DONE && state_n == DONE;
            if (accept) begin
                op     <= in_op;
                vsew   <= in_vsew;
                vs2    <= in_vs2;
                vl_eff <= vl_in;
                idx    <= '0;
                acc    <= legal ? sext(in_vs1, in_vsew) : '0;
                err    <= !legal;
            end else if (state == ACCUM) begin
                idx <= idx + IW'(1);
                acc <= op == 3'd1 ? sum : ($signed(e) > $signed(acc) ? e : acc);
            end
        end
endmodule

// File: tb/tb_v_red_unit.sv
// tb_v_red_unit: directed checks of v_red_unit results, latency, backpressure, reset and flush.
module tb_v_red_unit;
    logic         clk = 0, nrst = 0, in_valid = 0, flush = 0, out_ready = 1;
    logic         in_ready, out_valid, out_err;
    logic [2:0]   in_op = 0;
    logic [1:0]   in_vsew = 0;
    logic [4:0]   in_vl = 0;
    logic [127:0] in_vs2 = 0;
    logic [31:0]  in_vs1 = 0, out_result;
    int           n_chk = 0, n_fail = 0, lat;

    v_red_unit dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_vsew(in_vsew), .in_vl(in_vl), .in_vs2(in_vs2), .in_vs1(in_vs1), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request through its accept edge, then scramble inputs to show they are ignored.
    task automatic send(input logic [2:0] op, input logic [1:0] sew, input logic [4:0] vl,
                        input logic [127:0] vs2, input logic [31:0] vs1);
        in_op = op; in_vsew = sew; in_vl = vl; in_vs2 = vs2; in_vs1 = vs1; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; in_vs2 = {4{32'hDEADBEEF}}; in_vs1 = 32'h7777_7777; in_vl = 5'd16; in_op = 3'd2;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin n = i - 1; break; end
            @(posedge clk); #1;
        end
        if (n < 0) n = 99;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [1:0] sew,
                       input logic [4:0] vl, input logic [127:0] vs2, input logic [31:0] vs1,
                       input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        send(op, sew, vl, vs2, vs1);
        @(posedge clk); #1;
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat + 1), 32'(exp_lat));
        chk({tag, "_res"}, out_result, exp_res);
        chk({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'b0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_result", out_result, 32'h0);
        chk("rst_err", {31'b0, out_err}, 32'h0);
        @(posedge clk); #1 nrst = 1;
        @(posedge clk); #1;

        run("sum8", 3'd1, 2'd0, 5'd4, 128'h04030201, 32'd10, 32'h14, 0, 5);
        run("sum8_wrap", 3'd1, 2'd0, 5'd2, 128'h017F, 32'd0, 32'hFFFFFF80, 0, 3);
        run("max16_a", 3'd2, 2'd1, 5'd3, 128'h8000_0005_FFFF, 32'h3, 32'h5, 0, 4);
        run("max16_b", 3'd2, 2'd1, 5'd3, 128'h8000_0005_FFFF, 32'h7, 32'h7, 0, 4);
        run("max8_neg", 3'd2, 2'd0, 5'd3, 128'h90FE80, 32'h81, 32'hFFFFFFFE, 0, 4);
        run("sum32_clamp", 3'd1, 2'd2, 5'd20, {4{32'h1}}, 32'd0, 32'h4, 0, 5);
        run("sum8_vl_lim", 3'd1, 2'd0, 5'd1, 128'h0F09, 32'd1, 32'h0A, 0, 2);
        run("vl0", 3'd1, 2'd0, 5'd0, 128'hFF, 32'h55, 32'h55, 0, 1);
        run("bad_sew", 3'd1, 2'd3, 5'd2, 128'h0101, 32'h55, 32'h0, 1, 1);
        run("bad_op", 3'd0, 2'd0, 5'd2, 128'h0101, 32'h55, 32'h0, 1, 1);

        out_ready = 0;
        send(3'd1, 2'd0, 5'd1, 128'h5, 32'd1);
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_res", out_result, 32'h6);
            chk("hold_vr", {30'b0, out_valid, in_ready}, 32'h2);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("hold_release", {30'b0, out_valid, in_ready}, 32'h1);

        send(3'd1, 2'd0, 5'd4, 128'h04030201, 32'd10);
        @(posedge clk); @(posedge clk); #3;
        nrst = 0; #1;
        chk("arst_vr", {30'b0, out_valid, in_ready}, 32'h1);
        chk("arst_res", out_result, 32'h0);
        @(posedge clk); #1 nrst = 1;
        run("after_rst", 3'd1, 2'd0, 5'd4, 128'h04030201, 32'd10, 32'h14, 0, 5);

        out_ready = 0;
        send(3'd1, 2'd0, 5'd0, 128'h0, 32'h33);
        wait_valid(lat);
        chk("flush_pre", out_result, 32'h33);
        flush = 1;
        @(posedge clk); #1 flush = 0;
        chk("flush_vr", {30'b0, out_valid, in_ready}, 32'h1);
        out_ready = 1;
        run("after_flush", 3'd2, 2'd2, 5'd2, {32'h0, 32'h0, 32'hFFFFFFF0, 32'h8}, 32'h2, 32'h8, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
